// File: rtl/ring_rand_param.sv
// Append-only frequency-index ring: sequential replay port (circular or one-shot)
// plus a fully pipelined random-read port for register readback.
module ring_rand_param #(
  parameter int DATA_W   = 14,
  parameter int ADDR_W   = 7,
  parameter int RAND_LAT = 2
) (
  input  logic              dev_clk,
  input  logic              dev_aresetn,
  input  logic              clear,
  input  logic              rewind,
  input  logic              mode,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] din,
  output logic              full,
  output logic              wr_err,
  output logic [ADDR_W:0]   count,
  output logic              ready,
  input  logic              rd_en,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic [ADDR_W-1:0] index,
  output logic              done,
  input  logic              rand_rd_en,
  input  logic [ADDR_W-1:0] rand_rd_addr,
  output logic [DATA_W-1:0] rand_rd_data,
  output logic              rand_rd_valid,
  output logic              rand_rd_oob
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W-1:0] index_q, index_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] dout_q;
  logic              dout_valid_q;
  logic              wr_err_q;
  logic              normal_op, rd_acc, wr_ok, wr_drop, at_last;

  logic              rr_valid_q;
  logic              rr_oob_q;
  logic [DATA_W-1:0] rr_raw_q;

  // count is never above DEPTH, so its MSB alone marks full
  assign full      = count_q[ADDR_W];
  assign ready     = (count_q != '0);
  assign normal_op = ~clear & ~rewind;
  assign rd_acc    = rd_en & ready & ~done_q & normal_op;
  assign wr_ok     = wr_en & ~full & normal_op;
  assign wr_drop   = wr_en & full & normal_op;
  assign at_last   = ({1'b0, index_q} == (count_q - (ADDR_W+1)'(1)));

  always_comb begin
    count_d = count_q;
    index_d = index_q;
    done_d  = done_q;
    if (clear) begin
      count_d = '0;
      index_d = '0;
      done_d  = 1'b0;
    end else if (rewind) begin
      index_d = '0;
      done_d  = 1'b0;
    end else begin
      if (rd_acc) begin
        if (at_last) begin
          if (mode) done_d = 1'b1;
          else      index_d = '0;
        end else begin
          index_d = index_q + ADDR_W'(1);
        end
      end
      if (wr_ok) count_d = count_q + (ADDR_W+1)'(1);
    end
  end

  always_ff @(posedge dev_clk) begin
    if (wr_ok) mem[count_q[ADDR_W-1:0]] <= din;
  end

  always_ff @(posedge dev_clk or negedge dev_aresetn) begin
    if (!dev_aresetn) begin
      count_q      <= '0;
      index_q      <= '0;
      done_q       <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      wr_err_q     <= 1'b0;
      rr_valid_q   <= 1'b0;
      rr_oob_q     <= 1'b0;
      rr_raw_q     <= '0;
    end else begin
      count_q      <= count_d;
      index_q      <= index_d;
      done_q       <= done_d;
      dout_valid_q <= rd_acc;
      wr_err_q     <= wr_drop;
      if (rd_acc) dout_q <= mem[index_q];
      rr_valid_q <= rand_rd_en;
      // range test uses pre-write count, so a same-cycle write target is out of range
      if (rand_rd_en) begin
        rr_raw_q <= mem[rand_rd_addr];
        rr_oob_q <= ({1'b0, rand_rd_addr} >= count_q);
      end
    end
  end

  generate
    if (RAND_LAT == 1) begin : g_lat1
      assign rand_rd_valid = rr_valid_q;
      assign rand_rd_oob   = rr_oob_q;
      assign rand_rd_data  = rr_oob_q ? '0 : rr_raw_q;
    end else begin : g_lat2
      logic              rr2_valid_q;
      logic              rr2_oob_q;
      logic [DATA_W-1:0] rr2_data_q;
      always_ff @(posedge dev_clk or negedge dev_aresetn) begin
        if (!dev_aresetn) begin
          rr2_valid_q <= 1'b0;
          rr2_oob_q   <= 1'b0;
          rr2_data_q  <= '0;
        end else begin
          rr2_valid_q <= rr_valid_q;
          if (rr_valid_q) begin
            rr2_oob_q  <= rr_oob_q;
            rr2_data_q <= rr_oob_q ? '0 : rr_raw_q;
          end
        end
      end
      assign rand_rd_valid = rr2_valid_q;
      assign rand_rd_oob   = rr2_oob_q;
      assign rand_rd_data  = rr2_data_q;
    end
  endgenerate

  assign count      = count_q;
  assign index      = index_q;
  assign done       = done_q;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign wr_err     = wr_err_q;

endmodule

// File: tb/tb_ring_rand_param.sv
// Bench for ring_rand_param: queue-based behavioural model checked every cycle on
// the default-size instance, plus directed literal checks on a 4-deep RAND_LAT=1 instance.
module tb_ring_rand_param;
  localparam int DW = 14;
  localparam int AW = 7;
  localparam int LAT = 2;
  localparam int DEPTH = 128;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn = 1'b0;
  logic clear = 0, rewind = 0, mode = 0, wr_en = 0, rd_en = 0, rand_en = 0;
  logic [DW-1:0] din = '0;
  logic [AW-1:0] raddr = '0;
  logic full, wr_err, ready, dv, done, rvalid, roob;
  logic [AW:0] count;
  logic [DW-1:0] dout, rdata;
  logic [AW-1:0] index;

  logic s_wr_en = 0, s_rand_en = 0, s_zero = 0;
  logic [DW-1:0] s_din = '0;
  logic [1:0] s_raddr = '0;
  logic s_full, s_wr_err, s_ready, s_dv, s_done, s_rvalid, s_roob;
  logic [2:0] s_count;
  logic [DW-1:0] s_dout, s_rdata;
  logic [1:0] s_index;

  ring_rand_param #(.DATA_W(DW), .ADDR_W(AW), .RAND_LAT(LAT)) dut (
    .dev_clk(clk), .dev_aresetn(rstn), .clear(clear), .rewind(rewind), .mode(mode),
    .wr_en(wr_en), .din(din), .full(full), .wr_err(wr_err), .count(count), .ready(ready),
    .rd_en(rd_en), .dout(dout), .dout_valid(dv), .index(index), .done(done),
    .rand_rd_en(rand_en), .rand_rd_addr(raddr), .rand_rd_data(rdata),
    .rand_rd_valid(rvalid), .rand_rd_oob(roob)
  );

  ring_rand_param #(.DATA_W(DW), .ADDR_W(2), .RAND_LAT(1)) dut_s (
    .dev_clk(clk), .dev_aresetn(rstn), .clear(s_zero), .rewind(s_zero), .mode(s_zero),
    .wr_en(s_wr_en), .din(s_din), .full(s_full), .wr_err(s_wr_err), .count(s_count),
    .ready(s_ready), .rd_en(s_zero), .dout(s_dout), .dout_valid(s_dv), .index(s_index),
    .done(s_done), .rand_rd_en(s_rand_en), .rand_rd_addr(s_raddr), .rand_rd_data(s_rdata),
    .rand_rd_valid(s_rvalid), .rand_rd_oob(s_roob)
  );

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Behavioural model: list of stored entries, a cursor, and a time-stamped queue
  // of outstanding random reads.
  typedef struct { int due; int data; bit oob; } rr_t;
  rr_t rq[$];
  int  m_mem [DEPTH];
  int  m_cnt, m_idx, e_dout, e_rdata, cyc;
  bit  m_done, e_dv, e_werr, e_rv, e_roob;

  always @(posedge clk or negedge rstn) begin
    int oc;
    rr_t r;
    if (!rstn) begin
      m_cnt = 0; m_idx = 0; m_done = 0; e_dout = 0; e_dv = 0; e_werr = 0;
      e_rv = 0; e_rdata = 0; e_roob = 0; cyc = 0;
      rq.delete();
    end else begin
      oc = m_cnt;
      cyc++;
      if (rand_en) begin
        r.due  = cyc + LAT - 1;
        r.oob  = (int'(raddr) >= oc);
        r.data = r.oob ? 0 : m_mem[raddr];
        rq.push_back(r);
      end
      e_rv = 0;
      if (rq.size() > 0 && rq[0].due == cyc) begin
        e_rv = 1; e_rdata = rq[0].data; e_roob = rq[0].oob;
        void'(rq.pop_front());
      end
      e_dv = 0; e_werr = 0;
      if (clear) begin
        m_cnt = 0; m_idx = 0; m_done = 0;
      end else if (rewind) begin
        m_idx = 0; m_done = 0;
      end else begin
        e_werr = wr_en && (oc == DEPTH);
        if (rd_en && oc != 0 && !m_done) begin
          e_dout = m_mem[m_idx];
          e_dv = 1;
          if (m_idx == oc - 1) begin
            if (mode) m_done = 1;
            else m_idx = 0;
          end else m_idx++;
        end
        if (wr_en && oc < DEPTH) begin
          m_mem[oc] = int'(din);
          m_cnt = oc + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("full", full, m_cnt == DEPTH);
    chk("count", count, m_cnt);
    chk("ready", ready, m_cnt != 0);
    chk("wr_err", wr_err, e_werr);
    chk("dout_valid", dv, e_dv);
    chk("dout", dout, e_dout);
    chk("index", index, m_idx);
    chk("done", done, m_done);
    chk("rand_valid", rvalid, e_rv);
    chk("rand_data", rdata, e_rdata);
    chk("rand_oob", roob, e_roob);
  end

  task automatic step;
    @(negedge clk);
  endtask

  int wv[3] = '{5, 9, 12};
  int rv4[4] = '{5, 9, 12, 7};
  int sv[4] = '{11, 22, 33, 44};

  initial begin
    repeat (3) step();
    rstn = 1'b1;
    chk("rst_count", count, 0);
    chk("rst_dout_valid", dv, 0);
    chk("rst_rand_valid", rvalid, 0);

    for (int i = 0; i < 3; i++) begin
      wr_en = 1; din = DW'(wv[i]); step();
    end
    wr_en = 0;
    chk("wr_count3", count, 3);

    // circular replay
    rd_en = 1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("circ_dout", dout, wv[i % 3]);
      chk("circ_index", index, (i + 1) % 3);
      chk("circ_valid", dv, 1);
    end
    rd_en = 0; step();
    chk("circ_novalid", dv, 0);

    // back-to-back random reads 0,2,3
    rand_en = 1; raddr = 0; step();
    chk("rr_lat", rvalid, 0);
    raddr = 2; step();
    chk("rr0_valid", rvalid, 1); chk("rr0_data", rdata, 5); chk("rr0_oob", roob, 0);
    raddr = 3; step();
    chk("rr2_valid", rvalid, 1); chk("rr2_data", rdata, 12); chk("rr2_oob", roob, 0);
    rand_en = 0; step();
    chk("rr3_valid", rvalid, 1); chk("rr3_data", rdata, 0); chk("rr3_oob", roob, 1);
    step();
    chk("rr_end", rvalid, 0); chk("rr_hold_oob", roob, 1);

    // write and read together at the last entry
    rd_en = 1; step(); step();
    chk("pre_idx", index, 2);
    wr_en = 1; din = 7; step();
    wr_en = 0;
    chk("wrrd_dout", dout, 12); chk("wrrd_index", index, 0); chk("wrrd_count", count, 4);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("after_wr_dout", dout, rv4[i]);
    end
    rd_en = 0; step();

    // one-shot with rewind
    mode = 1; rd_en = 1; step();
    chk("os_first", index, 1);
    rewind = 1; step();
    rewind = 0;
    chk("rewind_idx", index, 0); chk("rewind_novalid", dv, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("os_dout", dout, rv4[i]);
    end
    chk("os_done", done, 1); chk("os_index", index, 3);
    step();
    chk("os_stop_valid", dv, 0); chk("os_hold_dout", dout, 7);
    mode = 0; step();
    chk("done_sticky", done, 1);
    rd_en = 0; rewind = 1; step();
    rewind = 0;
    chk("rewind_done", done, 0); chk("rewind_idx2", index, 0);
    rd_en = 1; step();
    rd_en = 0;
    chk("rewind_read", dout, 5);
    step();

    // clear with write, read and an in-flight random read
    rand_en = 1; raddr = 1; step();
    rand_en = 0; clear = 1; wr_en = 1; din = 33; rd_en = 1; step();
    clear = 0; wr_en = 0; rd_en = 0;
    chk("clr_count", count, 0); chk("clr_ready", ready, 0); chk("clr_wr_err", wr_err, 0);
    chk("clr_dv", dv, 0); chk("clr_rr_valid", rvalid, 1); chk("clr_rr_data", rdata, 9);
    rd_en = 1; step();
    rd_en = 0;
    chk("empty_rd", dv, 0);

    // asynchronous reset mid-stream
    for (int i = 0; i < 2; i++) begin
      wr_en = 1; din = DW'(i + 3); step();
    end
    wr_en = 0; rd_en = 1; rand_en = 1; raddr = 0; step();
    chk("pre_rst_dout", dout, 3);
    #2 rstn = 1'b0;
    #1;
    chk("arst_count", count, 0); chk("arst_dout", dout, 0); chk("arst_dv", dv, 0);
    chk("arst_index", index, 0); chk("arst_ready", ready, 0); chk("arst_rvalid", rvalid, 0);
    rd_en = 0; rand_en = 0;
    step();
    rstn = 1'b1;
    step();

    // 4-deep instance: full and overflow
    for (int i = 0; i < 4; i++) begin
      s_wr_en = 1; s_din = DW'(sv[i]); step();
    end
    chk("s_full", s_full, 1); chk("s_count", s_count, 4);
    s_din = 55; step();
    s_wr_en = 0;
    chk("s_wr_err", s_wr_err, 1); chk("s_count_hold", s_count, 4);
    step();
    chk("s_wr_err_pulse", s_wr_err, 0);
    for (int i = 0; i < 4; i++) begin
      s_rand_en = 1; s_raddr = 2'(i); step();
      chk("s_rr_valid", s_rvalid, 1); chk("s_rr_data", s_rdata, sv[i]); chk("s_rr_oob", s_roob, 0);
    end
    s_rand_en = 0; step();
    chk("s_rr_end", s_rvalid, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
